cam_stream_gen: RTL and testbench

CAM_STREAM_GEN -- requirements
Module: cam_stream_gen

---
 rtl/cam_stream_gen.sv | 158 +++++++++++++++
 tb/tb_cam_stream_gen.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cam_stream_gen.sv
// Camera-style YUV422 test stream generator (ramp, or colour bars when CAM_STREAM_BARS_EN is defined).
// Outputs are registered and change on the CLOCK_24 edge where PCLK falls; no backpressure.
module cam_stream_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic       CLOCK_24,
  input  logic       rst,
  input  logic       en,
  input  logic       pattern_sel,
  output logic       PCLK,
  output logic       VSYNC,
  output logic       HREF,
  output logic [7:0] D,
  output logic       frame_done,
  output logic [7:0] frame_cnt
);

  localparam int LINE  = 2*H_ACTIVE + H_BLANK;
  localparam int HW    = $clog2(LINE);
  localparam int VMAX1 = (V_SYNC > V_BACK) ? V_SYNC : V_BACK;
  localparam int VMAX2 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
  localparam int VMAX  = (VMAX1 > VMAX2) ? VMAX1 : VMAX2;
  localparam int VW    = $clog2(VMAX + 1);
  localparam logic [HW-1:0] H_LAST = HW'(LINE - 1);
  localparam logic [HW-1:0] H_HREF = HW'(2*H_ACTIVE);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [VW-1:0]   lines_m1;
  logic            line_end, v_last;
  logic            vsync_d, href_d, done_d;
  logic [7:0]      d_d;
  logic [HW-1:0]   px;

`ifdef CAM_STREAM_BARS_EN
  logic pat_q, pat_d;
  logic [1:0] bar;

  function automatic logic [7:0] bar_byte(input logic [1:0] b, input logic [1:0] kind);
    logic [7:0] y, cb, cr;
    case (b)
      2'd0:    begin y = 8'd76;  cb = 8'd85;  cr = 8'd255; end
      2'd1:    begin y = 8'd150; cb = 8'd44;  cr = 8'd21;  end
      2'd2:    begin y = 8'd226; cb = 8'd0;   cr = 8'd149; end
      default: begin y = 8'd29;  cb = 8'd255; cr = 8'd107; end
    endcase
    return kind[0] ? (kind[1] ? cr : cb) : y;
  endfunction
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
`endif

  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
`ifdef CAM_STREAM_BARS_EN
    pat_d    = pat_q;
`endif
    case (state_q)
      S_VSYNC:  lines_m1 = VW'(V_SYNC - 1);
      S_VBACK:  lines_m1 = VW'(V_BACK - 1);
      S_ACTIVE: lines_m1 = VW'(V_ACTIVE - 1);
      S_VFRONT: lines_m1 = VW'(V_FRONT - 1);
      default:  lines_m1 = '0;
    endcase
    line_end = (h_q == H_LAST);
    v_last   = (v_q == lines_m1);

    // Everything advances only on the period boundary, i.e. while PCLK is high.
    if (PCLK) begin
      if (state_q == S_IDLE) begin
        if (en) begin
          state_d = S_VSYNC;
          h_d     = '0;
          v_d     = '0;
`ifdef CAM_STREAM_BARS_EN
          pat_d   = pattern_sel;
`endif
        end
      end else if (!line_end) begin
        h_d = h_q + 1'b1;
      end else begin
        h_d = '0;
        if (!v_last) begin
          v_d = v_q + 1'b1;
        end else begin
          v_d = '0;
          case (state_q)
            S_VSYNC:  state_d = S_VBACK;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: state_d = S_VFRONT;
            default:  state_d = en ? S_VSYNC : S_IDLE;
          endcase
`ifdef CAM_STREAM_BARS_EN
          if (state_d == S_VSYNC) pat_d = pattern_sel;
`endif
        end
      end
    end

    // Registered one clock early so the pulse lands on the final clock of VFRONT.
    done_d  = !PCLK && (state_q == S_VFRONT) && line_end && v_last;

    vsync_d = (state_d == S_VSYNC);
    href_d  = (state_d == S_ACTIVE) && (h_d < H_HREF);
    px      = h_d >> 1;
    d_d     = 8'd0;
    if (href_d) d_d = h_d[0] ? 8'd128 : 8'(px);
`ifdef CAM_STREAM_BARS_EN
    if      (px < HW'(H_ACTIVE/4))   bar = 2'd0;
    else if (px < HW'(H_ACTIVE/2))   bar = 2'd1;
    else if (px < HW'(3*H_ACTIVE/4)) bar = 2'd2;
    else                             bar = 2'd3;
    if (href_d && pat_d) d_d = bar_byte(bar, h_d[1:0]);
`endif
  end

  always_ff @(posedge CLOCK_24) begin
    if (rst) begin
      state_q    <= S_IDLE;
      h_q        <= '0;
      v_q        <= '0;
      PCLK       <= 1'b0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      D          <= 8'd0;
      frame_done <= 1'b0;
      frame_cnt  <= 8'd0;
`ifdef CAM_STREAM_BARS_EN
      pat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      h_q        <= h_d;
      v_q        <= v_d;
      PCLK       <= !PCLK;
      VSYNC      <= vsync_d;
      HREF       <= href_d;
      D          <= d_d;
      frame_done <= done_d;
      if (done_d) frame_cnt <= frame_cnt + 8'd1;
`ifdef CAM_STREAM_BARS_EN
      pat_q      <= pat_d;
`endif
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Randomized bench for cam_stream_gen: outputs compared each clock against a frame-time reference model.
module tb_cam_stream_gen;

  localparam int HA = 4, HB = 2, VS = 1, VB = 1, VA = 2, VF = 1;
  localparam int LINE  = 2*HA + HB;
  localparam int FRAME = 2*LINE*(VS + VB + VA + VF);
  localparam int CYCLES = 3000;

  logic       CLOCK_24 = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       pattern_sel = 1'b0;
  logic       PCLK, VSYNC, HREF, frame_done;
  logic [7:0] D, frame_cnt;

  cam_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .CLOCK_24(CLOCK_24), .rst(rst), .en(en), .pattern_sel(pattern_sel),
    .PCLK(PCLK), .VSYNC(VSYNC), .HREF(HREF), .D(D),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 CLOCK_24 = ~CLOCK_24;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: whether a frame is running and how many clocks into it we are.
  bit         m_pclk = 0;
  bit         m_inf = 0;
  bit         m_pat = 0;
  int         m_t = 0;
  logic [7:0] m_cnt = 8'd0;

  function automatic logic [7:0] exp_byte(input int col, input bit pat);
    int x, k;
    logic [7:0] ytab [4], cbtab [4], crtab [4];
    x = col / 2;
    k = col % 4;
    ytab  = '{8'd76, 8'd150, 8'd226, 8'd29};
    cbtab = '{8'd85, 8'd44,  8'd0,   8'd255};
    crtab = '{8'd255, 8'd21, 8'd149, 8'd107};
`ifdef CAM_STREAM_BARS_EN
    if (pat) begin
      int b;
      b = (x * 4) / HA;
      if (k == 1) return cbtab[b];
      if (k == 3) return crtab[b];
      return ytab[b];
    end
`else
    if (pat && ytab[0] == 8'd0) return 8'd0;
`endif
    if (k % 2 == 1) return 8'd128;
    return 8'(x);
  endfunction

  task automatic model_step();
    bit tick;
    if (rst) begin
      m_pclk = 0; m_inf = 0; m_t = 0; m_cnt = 8'd0;
    end else begin
      tick   = m_pclk;
      m_pclk = !m_pclk;
      if (m_inf) begin
        m_t++;
        if (m_t == FRAME) begin
          m_t = 0;
          if (en) m_pat = pattern_sel;
          else    m_inf = 0;
        end
      end else if (tick && en) begin
        m_inf = 1; m_t = 0; m_pat = pattern_sel;
      end
      if (m_inf && m_t == FRAME - 1) m_cnt++;
    end
  endtask

  task automatic compare_outputs();
    bit e_vs, e_href, e_done;
    logic [7:0] e_d;
    int per, line, col;
    e_vs = 0; e_href = 0; e_done = 0; e_d = 8'd0;
    if (m_inf) begin
      per  = m_t / 2;
      line = per / LINE;
      col  = per % LINE;
      e_vs   = (line < VS);
      e_href = (line >= VS + VB) && (line < VS + VB + VA) && (col < 2*HA);
      e_d    = e_href ? exp_byte(col, m_pat) : 8'd0;
      e_done = (m_t == FRAME - 1);
    end
    check("pclk", 32'(PCLK), 32'(m_pclk));
    check("vsync", 32'(VSYNC), 32'(e_vs));
    check("href", 32'(HREF), 32'(e_href));
    check("d", 32'(D), 32'(e_d));
    check("frame_done", 32'(frame_done), 32'(e_done));
    check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
  endtask

  initial begin
    bit forced_rst;
    forced_rst = 0;
    for (int c = 0; c < CYCLES; c++) begin
      @(posedge CLOCK_24);
      model_step();
      #1;
      compare_outputs();
      // Next stimulus: held-en start, then random en/rst/pattern traffic, then a quiet tail to reach IDLE.
      if (c < 4) rst = 1'b1;
      else if (!forced_rst && c > 150 && HREF) begin
        rst = 1'b1;
        forced_rst = 1;
      end else rst = ($urandom_range(0, 249) == 0);
      if (c < 500) en = 1'b1;
      else if (c < CYCLES - 400) begin
        if ($urandom_range(0, 59) == 0) en = !en;
      end else en = 1'b0;
      if ($urandom_range(0, 29) == 0) pattern_sel = !pattern_sel;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
